// File: rtl/sipo_pkg.sv
// Shared types and helpers for the sipo_deser serial-in/parallel-out deserializer.
// Contents:
//   DEFAULT_WIDTH - default data word width
//   state_t       - deserializer FSM states (PARITY only reachable with SIPO_DESER_PARITY_EN)
//   cnt_width()   - width of a counter that must hold the values 0..width
package sipo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    // Bits needed to represent 0..width inclusive.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// Qualified-increment bit counter with synchronous clear and terminal-count decode.
// Ports:
//   clk, reset - rising-edge clock, asynchronous active-low reset
//   inc        - advance the count on this edge
//   clr        - synchronous clear, wins over inc
//   count      - current count (registered)
//   tc_c       - count == TERM (combinational decode of the register)
// On an inc at terminal count the counter returns to 0 instead of wrapping past TERM.
module sipo_bit_counter #(
    parameter int unsigned CW   = 3,
    parameter int unsigned TERM = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc_c
);

    assign tc_c = (count == CW'(TERM));

    // Count register: clear wins, terminal count folds back to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= tc_c ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer feeding a parallel holding register.
// Qualified serial bits are collected into a WIDTH-bit word; on completion the word
// is loaded into dout and dout_valid pulses for one cycle. dout holds between words.
// Ports:
//   clk, reset - rising-edge clock, asynchronous active-low reset
//   sin        - serial data bit, sampled when sin_valid is 1
//   sin_valid  - qualifies sin
//   clr        - synchronous flush of a partial word (beats sin_valid)
//   dout       - last completed word
//   dout_valid - one-cycle strobe on the cycle dout updates
//   busy       - a partial word is held
//   parity_err - parity result of the last frame (0 without the parity option)
// Build option: define SIPO_DESER_PARITY_EN to append an even-parity bit to every
// frame; the word is delivered on the parity-bit edge.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             parity_err
);

    localparam int unsigned CW = cnt_width(WIDTH);
`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned TERM = WIDTH;
`else
    localparam int unsigned TERM = WIDTH - 1;
`endif

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    count;
    logic             tc_c;
    logic             last_data_c;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_n;
    logic [WIDTH-1:0] shifted_c;
    logic [WIDTH-1:0] dout_n;
    logic             dv_n;
    logic             busy_n;

    // Counter tracks bits taken in the current frame, including the parity bit.
    sipo_bit_counter #(
        .CW   (CW),
        .TERM (TERM)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (sin_valid),
        .clr   (clr),
        .count (count),
        .tc_c  (tc_c)
    );

    // Shift register with the incoming bit applied, in the configured bit order.
    assign shifted_c = MSB_FIRST ? {sreg[WIDTH-2:0], sin} : {sin, sreg[WIDTH-1:1]};

`ifdef SIPO_DESER_PARITY_EN
    logic perr_q;
    logic perr_n;

    assign last_data_c = (count == CW'(WIDTH - 1));
    assign parity_err  = perr_q;
`else
    logic unused_count;

    // Without parity the terminal count is exactly the last data bit.
    assign last_data_c  = tc_c;
    assign unused_count = ^count;
    assign parity_err   = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
            perr_q     <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sreg       <= sreg_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
            busy       <= busy_n;
`ifdef SIPO_DESER_PARITY_EN
            perr_q     <= perr_n;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        dout_n  = dout;
        dv_n    = 1'b0;
        busy_n  = busy;
`ifdef SIPO_DESER_PARITY_EN
        perr_n  = perr_q;
`endif
        if (clr) begin
            state_n = IDLE;
            sreg_n  = '0;
            busy_n  = 1'b0;
        end else if (sin_valid) begin
            case (state)
                IDLE, SHIFT: begin
                    sreg_n = shifted_c;
                    if (last_data_c) begin
`ifdef SIPO_DESER_PARITY_EN
                        state_n = PARITY;
                        busy_n  = 1'b1;
`else
                        state_n = IDLE;
                        dout_n  = shifted_c;
                        dv_n    = 1'b1;
                        busy_n  = 1'b0;
`endif
                    end else begin
                        state_n = SHIFT;
                        busy_n  = 1'b1;
                    end
                end
`ifdef SIPO_DESER_PARITY_EN
                PARITY: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    if (tc_c) begin
                        dout_n = sreg;
                        dv_n   = 1'b1;
                        perr_n = (^sreg) ^ sin;
                    end
                end
`endif
                default: begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer; sits directly upstream of the 4-bit parallel-in/parallel-out holding register and drives its parallel data input.
- Collects qualified serial bits MSB-first into a WIDTH-bit word.
- On word completion, presents the word on dout with a one-cycle dout_valid strobe.
- Holds dout stable between words so the downstream register can capture it on any cycle.

Parameters:
- WIDTH, 4, data bits per word; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- sin  input  1  serial data bit.
- sin_valid  input  1  sin is sampled only on clock edges where this is 1.
- clr  input  1  synchronous flush of a partial word.
- dout  output  WIDTH  last completed word.
- dout_valid  output  1  one-cycle pulse on the cycle dout updates.
- busy  output  1  1 while a partial word is held (bit count nonzero).
- parity_err  output  1  parity result of the last frame; tied 0 when the optional feature is absent.

Behaviour:
- Reset (reset==0, asynchronous) forces:
  - dout=0, dout_valid=0, busy=0, parity_err=0
  - internal shift register=0, bit count=0, state=IDLE.
- Reset deassertion is sampled synchronously; first capture is possible on the first edge with reset==1.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the feature).
- IDLE:
  - sin_valid=1 captures bit 0, count becomes 1, next state SHIFT.
  - Exception: when WIDTH bits are already satisfied, the word-complete rule applies.
- SHIFT:
  - Each sin_valid=1 captures one bit and increments count.
  - The edge that captures bit WIDTH-1 (word-complete edge) does all of the following at once:
    - loads dout with the full word, including that bit;
    - asserts dout_valid for exactly the following cycle;
    - returns count to 0 and state to IDLE.
- Latency: dout and dout_valid are visible one clock after the edge sampling the last bit. No combinational path from sin to dout.
- sin_valid=0 means hold: count, shift register, dout and state are unchanged. Gaps of any length are allowed mid-word.
- Back-to-back words:
  - With sin_valid held at 1, a new word starts on the edge after the word-complete edge.
  - dout_valid pulses every WIDTH cycles and is never high two consecutive cycles when WIDTH>=2.
- Bit order:
  - MSB_FIRST=1: shift left, new bit enters LSB.
  - MSB_FIRST=0: shift right, new bit enters MSB.
- clr=1 on an edge:
  - discards the partial word (count=0, state=IDLE);
  - dout is unchanged and dout_valid=0 that cycle;
  - clr has priority over a simultaneous sin_valid, and that bit is dropped.
- Reset mid-word: the partial word is lost. dout returns to 0 without a dout_valid pulse.
- busy = (count != 0), registered.
- Count register width is clog2(WIDTH+1). Count never exceeds WIDTH-1 (WIDTH with parity) and never wraps.

Optional Feature:
- Macro: SIPO_DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH data bits followed by one even-parity bit.
  - After data bit WIDTH-1 the state goes to PARITY, and dout is not yet updated.
  - The next qualified bit is the parity bit. On that edge:
    - dout loads the word and dout_valid pulses;
    - parity_err = XOR(data bits) XOR parity bit, held until the next frame completes or reset;
    - state returns to IDLE.
  - clr in PARITY discards the frame and leaves parity_err unchanged.
- Undefined: no PARITY state; parity_err is constant 0.

Decomposition:
- Shared package sipo_pkg contains:
  - state enum type (IDLE, SHIFT, PARITY);
  - function computing the count width from WIDTH;
  - constant default WIDTH=4.
- One sub-module, sipo_bit_counter: qualified-increment counter with sync clear, async active-low reset, and a terminal-count output. The top holds the shift register, FSM and output registers.

Test Plan:
- Reset then stream 1,0,1,1 with sin_valid=1 every cycle (WIDTH=4, MSB_FIRST=1) -> dout=4'b1011, dout_valid high exactly one cycle, on the cycle after the 4th bit edge.
- Same bits with sin_valid gaps of 0, 3 and 1 cycles between bits -> identical dout=4'b1011, single strobe; busy=1 from the first bit until the strobe cycle.
- Two consecutive words 1100 then 0011, no gaps -> dout=4'b1100, then 4'b0011 four cycles later; one strobe per word.
- Send 1,0 then clr=1 together with sin_valid=1, then send 0,1,1,0 -> dout=4'b0110; earlier dout unchanged and no strobe at clr.
- Send 1,1 then pulse reset low asynchronously between edges -> dout, busy and dout_valid go to 0 immediately; next full word 1001 yields dout=4'b1001.
- With SIPO_DESER_PARITY_EN: frame 1,0,1,1 then parity 1 -> dout=4'b1011, parity_err=0; frame 1,0,1,1 then parity 0 -> parity_err=1.
